// File: rtl/register_file_sb.sv
// Register file with a hardwired-zero register, optional write-to-read
// bypass and a per-register busy scoreboard with a running busy count.
module register_file_sb #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = DEPTH - 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             write_enable,
   input  logic [AW-1:0]    write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic [AW-1:0]    read_addr_1,
   input  logic [AW-1:0]    read_addr_2,
   output logic [WIDTH-1:0] read_data_1,
   output logic [WIDTH-1:0] read_data_2,
   input  logic             reserve_enable,
   input  logic [AW-1:0]    reserve_addr,
   output logic             busy_1,
   output logic             busy_2,
   output logic [CW-1:0]    busy_count
);

   localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

   logic [DEPTH-1:0][WIDTH-1:0] regs_q;
   logic [DEPTH-1:0]            busy_q;
   logic [DEPTH-1:0]            busy_d;
   logic [CW-1:0]               cnt_q;
   logic [CW-1:0]               cnt_d;

   logic wr_ok;
   logic rs_ok;
   logic inc;
   logic dec;

   assign wr_ok = write_enable && (write_addr != ZR);
   assign rs_ok = reserve_enable && (reserve_addr != ZR);

   always_comb begin
      busy_d = busy_q;
      if (wr_ok) busy_d[write_addr] = 1'b0;
      if (rs_ok) busy_d[reserve_addr] = 1'b1;
      busy_d[ZR] = 1'b0;
   end

   // Count tracks popcount(busy) incrementally: a reserve of a free
   // register adds one, a release not overridden by a reserve removes one.
   always_comb begin
      inc   = rs_ok && !busy_q[reserve_addr];
      dec   = wr_ok && busy_q[write_addr]
              && !(rs_ok && (reserve_addr == write_addr));
      cnt_d = cnt_q;
      if (inc && !dec) cnt_d = cnt_q + CW'(1);
      if (dec && !inc) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok) regs_q[write_addr] <= write_data;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   logic hit_1;
   logic hit_2;

   assign hit_1 = (BYPASS != 0) && write_enable && (write_addr == read_addr_1);
   assign hit_2 = (BYPASS != 0) && write_enable && (write_addr == read_addr_2);

   always_comb begin
      read_data_1 = regs_q[read_addr_1];
      if (hit_1) read_data_1 = write_data;
      if (read_addr_1 == ZR) read_data_1 = '0;
   end

   always_comb begin
      read_data_2 = regs_q[read_addr_2];
      if (hit_2) read_data_2 = write_data;
      if (read_addr_2 == ZR) read_data_2 = '0;
   end

   // A bypassed writeback releases busy early unless it is re-reserved now.
   assign busy_1 = busy_q[read_addr_1] && (read_addr_1 != ZR)
                   && !(hit_1 && !(reserve_enable
                                   && (reserve_addr == read_addr_1)));
   assign busy_2 = busy_q[read_addr_2] && (read_addr_2 != ZR)
                   && !(hit_2 && !(reserve_enable
                                   && (reserve_addr == read_addr_2)));

   assign busy_count = cnt_q;

endmodule
